dmem_io_unit: RTL and testbench

- Data-side memory and I/O unit on the single-cycle CPU data port; consumes Wmem/Daddr/Dwrite, returns Dread in the same cycle.
- Decodes Daddr into word RAM, a free-running timer with compare/interrupt, and a console TX FIFO drained over a valid/ready byte stream.
- Reads are combinational (the CPU completes loads in one cycle); all state updates occur at posedge Clk.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/sync_fifo8.sv | 54 +++++
 rtl/dmem_io_unit.sv | 136 +++++++++++++
 tb/tb_dmem_io_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the CPU data-side unit: address regions, I/O register indices, status bit positions.
package cpu_pkg;

    localparam logic [3:0] RAM_REGION = 4'h0;
    localparam logic [3:0] IO_REGION  = 4'hF;

    // I/O register index is the byte offset divided by 4 (Daddr[4:2])
    localparam logic [2:0] REG_COUNT    = 3'd0;
    localparam logic [2:0] REG_CMP      = 3'd1;
    localparam logic [2:0] REG_CTRL     = 3'd2;
    localparam logic [2:0] REG_TSTAT    = 3'd3;
    localparam logic [2:0] REG_CON_DATA = 3'd4;
    localparam logic [2:0] REG_CON_STAT = 3'd5;

    localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IE_BIT     = 1;
    localparam int TSTAT_MATCH_BIT = 0;
    localparam int CSTAT_FULL_BIT  = 0;
    localparam int CSTAT_EMPTY_BIT = 1;
    localparam int CSTAT_OVF_BIT   = 2;
    localparam int CSTAT_CNT_LSB   = 8;

endpackage

// File: rtl/sync_fifo8.sv
// Byte FIFO with registered head; push ignored when full (a same-cycle pop does not make room).
// Head visible combinationally from storage; pop when empty is ignored.
module sync_fifo8 #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [7:0]    i_dat,
    input  logic          i_pop,
    output logic [7:0]    o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_dat;
    end

endmodule

// File: rtl/dmem_io_unit.sv
// Data-port RAM, timer and console FIFO; loads combinational, stores at posedge Clk.
// Console drained by Tx_valid/Tx_ready; stores to a full console are dropped and flagged ovf.
module dmem_io_unit
    import cpu_pkg::*;
#(
    parameter int RAM_AW     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [31:0] Daddr,
    input  logic [31:0] Dwrite,
    input  logic        Wmem,
    output logic [31:0] Dread,
    output logic [7:0]  Tx_data,
    output logic        Tx_valid,
    input  logic        Tx_ready,
    output logic        Irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       r_ram [2**RAM_AW];
    logic [31:0]       r_count;
    logic [31:0]       r_cmp;
    logic              r_en;
    logic              r_ie;
    logic              r_match;
    logic              r_ovf;

    logic              w_sel_ram;
    logic              w_sel_io;
    logic [2:0]        w_reg;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_wr_io;
    logic              w_wr_count;
    logic              w_hit;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_fifo_cnt;
    logic [31:0]       w_con_stat;

    assign w_sel_ram  = (Daddr[31:28] == RAM_REGION);
    assign w_sel_io   = (Daddr[31:28] == IO_REGION);
    assign w_reg      = Daddr[4:2];
    assign w_ram_idx  = Daddr[RAM_AW+1:2];
    assign w_wr_io    = Wmem & w_sel_io;
    assign w_wr_count = w_wr_io & (w_reg == REG_COUNT);
    assign w_push     = w_wr_io & (w_reg == REG_CON_DATA);
    assign w_pop      = Tx_valid & Tx_ready;
    assign w_hit      = r_en & (r_count == r_cmp) & ~w_wr_count;

    assign Tx_valid = ~w_empty;
    assign Irq      = r_match & r_ie;

    always_ff @(posedge Clk) begin
        if (Wmem && w_sel_ram) r_ram[w_ram_idx] <= Dwrite;
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_count <= '0;
            r_cmp   <= CMP_RST;
            r_en    <= 1'b0;
            r_ie    <= 1'b0;
            r_match <= 1'b0;
        end else begin
            // A CPU write to COUNT takes precedence over the timer advancing.
            if (w_wr_count)     r_count <= Dwrite;
            else if (w_hit)     r_count <= '0;
            else if (r_en)      r_count <= r_count + 32'd1;

            if (w_wr_io && w_reg == REG_CMP) r_cmp <= Dwrite;
            if (w_wr_io && w_reg == REG_CTRL) begin
                r_en <= Dwrite[CTRL_EN_BIT];
                r_ie <= Dwrite[CTRL_IE_BIT];
            end

            if (w_hit)
                r_match <= 1'b1;
            else if (w_wr_io && w_reg == REG_TSTAT && Dwrite[TSTAT_MATCH_BIT])
                r_match <= 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_ovf <= 1'b0;
        end else if (w_push && w_full) begin
            r_ovf <= 1'b1;
        end else if (w_wr_io && w_reg == REG_CON_STAT && Dwrite[CSTAT_OVF_BIT]) begin
            r_ovf <= 1'b0;
        end
    end

    sync_fifo8 #(
        .DEPTH (FIFO_DEPTH)
    ) u_con_fifo (
        .clk     (Clk),
        .rst     (Clr),
        .i_push  (w_push),
        .i_dat   (Dwrite[7:0]),
        .i_pop   (w_pop),
        .o_head  (Tx_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_cnt)
    );

    always_comb begin
        w_con_stat                              = '0;
        w_con_stat[CSTAT_FULL_BIT]              = w_full;
        w_con_stat[CSTAT_EMPTY_BIT]             = w_empty;
        w_con_stat[CSTAT_OVF_BIT]               = r_ovf;
        w_con_stat[CSTAT_CNT_LSB +: CW]         = w_fifo_cnt;
    end

    always_comb begin
        Dread = '0;
        if (w_sel_ram) begin
            Dread = r_ram[w_ram_idx];
        end else if (w_sel_io) begin
            case (w_reg)
                REG_COUNT:    Dread = r_count;
                REG_CMP:      Dread = r_cmp;
                REG_CTRL:     Dread = {30'd0, r_ie, r_en};
                REG_TSTAT:    Dread = {31'd0, r_match};
                REG_CON_STAT: Dread = w_con_stat;
                default:      Dread = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_io_unit.sv
// Directed bench for dmem_io_unit: RAM, timer, console FIFO and reset, expected values worked out by hand.
module tb_dmem_io_unit;

    localparam logic [31:0] A_COUNT = 32'hF000_0000;
    localparam logic [31:0] A_CMP   = 32'hF000_0004;
    localparam logic [31:0] A_CTRL  = 32'hF000_0008;
    localparam logic [31:0] A_TSTAT = 32'hF000_000C;
    localparam logic [31:0] A_CDATA = 32'hF000_0010;
    localparam logic [31:0] A_CSTAT = 32'hF000_0014;

    logic        Clk = 1'b0;
    logic        Clr;
    logic [31:0] Daddr;
    logic [31:0] Dwrite;
    logic        Wmem;
    logic [31:0] Dread;
    logic [7:0]  Tx_data;
    logic        Tx_valid;
    logic        Tx_ready;
    logic        Irq;

    int n_checks = 0;
    int n_pass   = 0;

    dmem_io_unit #(.RAM_AW(10), .FIFO_DEPTH(4)) dut (
        .Clk      (Clk),
        .Clr      (Clr),
        .Daddr    (Daddr),
        .Dwrite   (Dwrite),
        .Wmem     (Wmem),
        .Dread    (Dread),
        .Tx_data  (Tx_data),
        .Tx_valid (Tx_valid),
        .Tx_ready (Tx_ready),
        .Irq      (Irq)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Daddr  = a;
        Dwrite = d;
        Wmem   = 1'b1;
        tick();
        Wmem   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Daddr = a;
        #1;
        chk(tag, Dread, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Clr = 1'b1; Wmem = 1'b0; Daddr = '0; Dwrite = '0; Tx_ready = 1'b0;
        #1;
        chk("rst_txv", 32'(Tx_valid), 32'd0);
        chk("rst_irq", 32'(Irq), 32'd0);
        rd("rst_count", A_COUNT, 32'd0);
        rd("rst_cmp", A_CMP, 32'hFFFF_FFFF);
        rd("rst_cstat", A_CSTAT, 32'h0000_0002);
        tick();
        Clr = 1'b0;
        tick();

        // RAM
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_lowbits", 32'h0000_0013, 32'hDEAD_BEEF);
        rd("ram_alias", 32'h0000_1010, 32'hDEAD_BEEF);
        rd("unmapped", 32'h2000_0010, 32'd0);
        Daddr = 32'h0000_0010; Dwrite = 32'h1234_5678; Wmem = 1'b1;
        #1;
        chk("ram_old_same_cycle", Dread, 32'hDEAD_BEEF);
        tick();
        Wmem = 1'b0;
        rd("ram_new", 32'h0000_0010, 32'h1234_5678);
        wr(32'h2000_0010, 32'hAAAA_5555);
        rd("unmapped_wr_ignored", 32'h0000_0010, 32'h1234_5678);

        // Timer count sequence and match
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'd1);
        rd("tmr_c0", A_COUNT, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            rd($sformatf("tmr_c%0d", i), A_COUNT, 32'(i % 4));
        end
        rd("tmr_match", A_TSTAT, 32'd1);
        chk("tmr_irq_masked", 32'(Irq), 32'd0);
        wr(A_CTRL, 32'd3);
        chk("tmr_irq_on", 32'(Irq), 32'd1);
        wr(A_TSTAT, 32'd1);
        chk("tmr_irq_cleared", 32'(Irq), 32'd0);
        rd("tmr_c2", A_COUNT, 32'd2);
        tick();
        rd("tmr_c3", A_COUNT, 32'd3);
        wr(A_TSTAT, 32'd1);
        rd("tmr_set_wins", A_TSTAT, 32'd1);
        chk("tmr_set_wins_irq", 32'(Irq), 32'd1);
        rd("tmr_wrap0", A_COUNT, 32'd0);

        // COUNT write overrides increment
        wr(A_COUNT, 32'h100);
        rd("tmr_wr_prio", A_COUNT, 32'h100);
        wr(A_CTRL, 32'd0);
        tick();
        rd("tmr_hold", A_COUNT, 32'h101);
        wr(A_TSTAT, 32'd1);

        // 32-bit wraparound without match when cmp differs
        wr(A_COUNT, 32'hFFFF_FFFF);
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'd1);
        rd("tmr_pre_wrap", A_COUNT, 32'hFFFF_FFFF);
        tick();
        rd("tmr_wrap32", A_COUNT, 32'd0);
        rd("tmr_wrap32_nomatch", A_TSTAT, 32'd0);
        wr(A_CTRL, 32'd0);

        // FIFO fill, overflow and drain
        for (int i = 0; i < 4; i++) wr(A_CDATA, 32'h41 + 32'(i));
        rd("fifo_full_stat", A_CSTAT, 32'h0000_0401);
        chk("fifo_head", 32'(Tx_data), 32'h41);
        chk("fifo_valid", 32'(Tx_valid), 32'd1);
        rd("con_data_rd0", A_CDATA, 32'd0);
        wr(A_CDATA, 32'h45);
        rd("fifo_ovf_stat", A_CSTAT, 32'h0000_0405);
        chk("fifo_head_stable", 32'(Tx_data), 32'h41);
        Tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("drain_v%0d", i), 32'(Tx_valid), 32'd1);
            chk($sformatf("drain_d%0d", i), 32'(Tx_data), 32'h41 + 32'(i));
            tick();
        end
        Tx_ready = 1'b0;
        chk("drain_empty_v", 32'(Tx_valid), 32'd0);
        rd("drain_stat", A_CSTAT, 32'h0000_0006);
        wr(A_CSTAT, 32'h4);
        rd("ovf_clr", A_CSTAT, 32'h0000_0002);
        Tx_ready = 1'b1;
        tick();
        Tx_ready = 1'b0;
        rd("pop_empty", A_CSTAT, 32'h0000_0002);

        // Simultaneous push and pop
        wr(A_CDATA, 32'h50);
        wr(A_CDATA, 32'h51);
        Tx_ready = 1'b1;
        wr(A_CDATA, 32'h52);
        Tx_ready = 1'b0;
        rd("pushpop_cnt", A_CSTAT, 32'h0000_0200);
        chk("pushpop_head", 32'(Tx_data), 32'h51);
        Tx_ready = 1'b1;
        tick();
        chk("pushpop_next", 32'(Tx_data), 32'h52);
        tick();
        Tx_ready = 1'b0;
        chk("pushpop_empty", 32'(Tx_valid), 32'd0);

        // Push while full with concurrent pop: push still dropped
        for (int i = 0; i < 4; i++) wr(A_CDATA, 32'h60 + 32'(i));
        Tx_ready = 1'b1;
        wr(A_CDATA, 32'h64);
        Tx_ready = 1'b0;
        rd("full_pushpop_stat", A_CSTAT, 32'h0000_0304);
        chk("full_pushpop_head", 32'(Tx_data), 32'h61);

        // Timer running with interrupt, then reset mid-stream
        wr(A_COUNT, 32'd0);
        wr(A_CMP, 32'd1);
        wr(A_CTRL, 32'd3);
        tick();
        tick();
        chk("pre_rst_irq", 32'(Irq), 32'd1);
        #2;
        Clr = 1'b1;
        #1;
        chk("rst_mid_txv", 32'(Tx_valid), 32'd0);
        chk("rst_mid_irq", 32'(Irq), 32'd0);
        rd("rst_mid_count", A_COUNT, 32'd0);
        rd("rst_mid_cmp", A_CMP, 32'hFFFF_FFFF);
        rd("rst_mid_cstat", A_CSTAT, 32'h0000_0002);
        @(negedge Clk);
        Clr = 1'b0;
        tick();
        rd("ram_retained", 32'h0000_0010, 32'h1234_5678);
        rd("ctrl_cleared", A_CTRL, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
